axil_dna_reader: RTL and testbench
==================================

Name: axil_dna_reader

Overview:
AXI4-Lite read-only master that fetches the device-DNA register block (words 0-3: DNA[31:0], DNA[63:32], DNA[95:64], family code) from an AXI4-Lite DNA responder. It polls until the responder reports a populated DNA, masks the value and compares it against a build-time expected ID. It drives match/valid status for licence-gating logic and sits on the same AXI-Lite interconnect as the responder, as an initiator.

Parameters:
ADDR_WIDTH, 16, AXI-Lite address width.
DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
BASE_ADDR, 16'h0000, byte address of DNA word 0; word n is at BASE_ADDR + 4*n.
EXPECTED_DNA, 96'h0, expected DNA value.
DNA_MASK, 96'h01FF_FFFF_FFFF_FFFF, compare mask: 57 bits for 7-series; set all-ones for 96-bit parts.
POLL_CYCLES, 1024, idle cycles between retries when the DNA is not ready; must be >= 1.
MAX_RETRIES, 16, number of not-ready passes before timeout; must be >= 1.

Ports:
m_axil_clk  in  1  clock.
m_axil_rstn  in  1  reset, asynchronous, active-low.
start  in  1  single-cycle request to run a fetch sequence.
m_axil_araddr  out  ADDR_WIDTH  read address.
m_axil_arprot  out  3  constant 3'b000.
m_axil_arvalid  out  1  read address valid.
m_axil_arready  in  1  read address ready.
m_axil_rdata  in  DATA_WIDTH  read data.
m_axil_rresp  in  2  read response.
m_axil_rvalid  in  1  read data valid.
m_axil_rready  out  1  read data ready.
busy  out  1  high while a sequence is in progress.
done  out  1  one-cycle pulse when a sequence ends, on any outcome.
dna_valid  out  1  sticky; DNA captured successfully.
dna_match  out  1  sticky; (dna & DNA_MASK) == (EXPECTED_DNA & DNA_MASK).
family  out  32  captured word 3.
dna  out  96  captured {word2, word1, word0}.
err_resp  out  1  sticky; a non-OKAY rresp was received.
err_timeout  out  1  sticky; MAX_RETRIES not-ready passes occurred.

Behaviour:
- Reset (async assert, sync release): state IDLE. arvalid=0, rready=0, araddr=BASE_ADDR. busy, done, dna_valid, dna_match and both err flags = 0. dna=0, family=0. Word index and retry counter = 0.
- States: IDLE, AR, R, CHECK, WAIT, DONE.
- IDLE: on start=1, clear all sticky flags, idx=0, retry=0, go to AR. busy=1 from the next cycle.
- AR: araddr = BASE_ADDR + 4*idx; arvalid=1. arvalid and araddr stay stable until arvalid&&arready. That cycle moves to R.
  - There is no abort once arvalid is asserted.
- R: rready=1. On rvalid:
  - latch rdata into shadow word[idx].
  - If rresp != 2'b00: set err_resp and go to DONE.
  - Else if idx<3: idx++ and go to AR.
  - Else go to CHECK.
- Only one read is outstanding at a time. The earliest arvalid->arvalid spacing is 2 cycles (AR, R).
- CHECK, one cycle:
  - Not-ready condition: word3==0, or words 0..2 all zero.
  - If not ready: retry++. If retry==MAX_RETRIES, set err_timeout and go to DONE. Otherwise load the wait counter with POLL_CYCLES and go to WAIT.
  - If ready: dna <= {word2, word1, word0}; family <= word3; dna_valid <= 1; dna_match <= masked compare. Go to DONE.
- WAIT: decrement the counter each cycle; at 0, set idx=0 and go to AR. Exactly POLL_CYCLES cycles are spent in WAIT.
- DONE: done=1 for one cycle, busy drops to 0, go to IDLE. dna, family and flags hold until the next start.
- start while busy=1 is ignored: no restart, no queueing. start in the DONE cycle is also ignored.
- dna and family are only updated on a successful CHECK. A failed or timed-out sequence leaves them at 0, because they are cleared at start.
- Reset asserted mid-transaction returns to IDLE immediately, dropping arvalid/rready. The interconnect is reset by the same rstn.
- Latency, zero-wait responder with arready/rvalid each one cycle after request: 4 words x 2 cycles + CHECK + DONE = 10 cycles from start to done.

Test Plan:
- Responder returns DNA words 0x04050607, 0x00010203, 0x0, family 0x7; EXPECTED_DNA=96'h0000_0000_0001_0203_0405_0607 -> 4 reads at 0x0/0x4/0x8/0xC, done pulse, dna_valid=1, dna_match=1, family=7, busy high 10 cycles.
- Same data, EXPECTED_DNA differs only in bit 60 (masked out) -> dna_match=1. Differing in bit 0 -> dna_match=0, dna_valid=1.
- Responder returns all zeros for 2 passes, then valid data; POLL_CYCLES=8 -> 12 reads, 8-cycle gaps between passes, dna_valid=1, err_timeout=0.
- Responder always returns zeros, MAX_RETRIES=3 -> exactly 12 reads, err_timeout=1, dna_valid=0, dna=0, single done pulse.
- rresp=2'b10 on word 1 -> reads stop after word 1, err_resp=1, done pulses, dna_valid=0.
- Random arready/rvalid stalls up to 5 cycles plus start pulses while busy -> araddr/arvalid stable under stall, no extra sequences. Reset asserted during R -> arvalid=rready=busy=0 asynchronously.

Source files
------------

// File: rtl/axil_dna_reader.sv
// AXI4-Lite read-only initiator that fetches the device-DNA block, polls until it is
// populated, and reports a masked match against a build-time expected ID.
module axil_dna_reader #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 16'h0000,
  parameter logic [95:0]           EXPECTED_DNA = 96'h0,
  parameter logic [95:0]           DNA_MASK     = 96'h01FF_FFFF_FFFF_FFFF,
  parameter int                    POLL_CYCLES  = 1024,
  parameter int                    MAX_RETRIES  = 16
) (
  input  logic                  m_axil_clk,
  input  logic                  m_axil_rstn,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic                  busy,
  output logic                  done,
  output logic                  dna_valid,
  output logic                  dna_match,
  output logic [31:0]           family,
  output logic [95:0]           dna,
  output logic                  err_resp,
  output logic                  err_timeout
);

  localparam int WW = $clog2(POLL_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_R     = 3'd2,
    S_CHECK = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state;
  logic [1:0]            r_idx;
  logic [RW-1:0]         r_retry;
  logic [WW-1:0]         r_wait;
  logic [31:0]           r_word [4];
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_dna_valid;
  logic                  r_dna_match;
  logic [31:0]           r_family;
  logic [95:0]           r_dna;
  logic                  r_err_resp;
  logic                  r_err_timeout;

  logic [95:0]           w_dna_cand;
  logic                  w_not_ready;
  logic                  w_match;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [1:0] idx);
    return BASE_ADDR + ADDR_WIDTH'({idx, 2'b00});
  endfunction

  // A block is "not ready" while the responder still shows an unpopulated DNA or family.
  assign w_dna_cand  = {r_word[2], r_word[1], r_word[0]};
  assign w_not_ready = (r_word[3] == 32'd0) || (w_dna_cand == 96'd0);
  assign w_match     = ((w_dna_cand & DNA_MASK) == (EXPECTED_DNA & DNA_MASK));

  // Sequencer: word fetch, readiness check, poll back-off and status capture.
  always_ff @(posedge m_axil_clk or negedge m_axil_rstn) begin
    if (!m_axil_rstn) begin
      r_state       <= S_IDLE;
      r_idx         <= 2'd0;
      r_retry       <= '0;
      r_wait        <= '0;
      r_word[0]     <= 32'd0;
      r_word[1]     <= 32'd0;
      r_word[2]     <= 32'd0;
      r_word[3]     <= 32'd0;
      r_araddr      <= BASE_ADDR;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_dna_valid   <= 1'b0;
      r_dna_match   <= 1'b0;
      r_family      <= 32'd0;
      r_dna         <= 96'd0;
      r_err_resp    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_dna_valid   <= 1'b0;
            r_dna_match   <= 1'b0;
            r_err_resp    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_dna         <= 96'd0;
            r_family      <= 32'd0;
            r_idx         <= 2'd0;
            r_retry       <= '0;
            r_araddr      <= word_addr(2'd0);
            r_arvalid     <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_AR;
          end
        end
        S_AR: begin
          if (m_axil_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (m_axil_rvalid) begin
            r_rready      <= 1'b0;
            r_word[r_idx] <= m_axil_rdata[31:0];
            if (m_axil_rresp != 2'b00) begin
              r_err_resp <= 1'b1;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else if (r_idx != 2'd3) begin
              r_idx     <= r_idx + 2'd1;
              r_araddr  <= word_addr(r_idx + 2'd1);
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
            end else begin
              r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (w_not_ready) begin
            r_retry <= r_retry + RW'(1);
            if (r_retry == RW'(MAX_RETRIES - 1)) begin
              r_err_timeout <= 1'b1;
              r_done        <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              r_wait  <= WW'(POLL_CYCLES);
              r_state <= S_WAIT;
            end
          end else begin
            r_dna       <= w_dna_cand;
            r_family    <= r_word[3];
            r_dna_valid <= 1'b1;
            r_dna_match <= w_match;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_WAIT: begin
          // The counter value 1 marks the last of POLL_CYCLES idle cycles.
          if (r_wait <= WW'(1)) begin
            r_wait    <= '0;
            r_idx     <= 2'd0;
            r_araddr  <= word_addr(2'd0);
            r_arvalid <= 1'b1;
            r_state   <= S_AR;
          end else begin
            r_wait <= r_wait - WW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign m_axil_araddr  = r_araddr;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = r_arvalid;
  assign m_axil_rready  = r_rready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign dna_valid      = r_dna_valid;
  assign dna_match      = r_dna_match;
  assign family         = r_family;
  assign dna            = r_dna;
  assign err_resp       = r_err_resp;
  assign err_timeout    = r_err_timeout;

endmodule

// File: tb/tb_axil_dna_reader.sv
// Directed bench for axil_dna_reader with a small AXI-Lite DNA responder model.
module tb_axil_dna_reader;

  localparam logic [95:0] EXP_DNA = 96'h0000_0000_0001_0203_0405_0607;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        busy;
  logic        done;
  logic        dna_valid;
  logic        dna_match;
  logic [31:0] family;
  logic [95:0] dna;
  logic        err_resp;
  logic        err_timeout;

  always #5 clk = ~clk;

  axil_dna_reader #(
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (32),
    .BASE_ADDR   (16'h0000),
    .EXPECTED_DNA(EXP_DNA),
    .DNA_MASK    (96'h01FF_FFFF_FFFF_FFFF),
    .POLL_CYCLES (8),
    .MAX_RETRIES (3)
  ) dut (
    .m_axil_clk    (clk),
    .m_axil_rstn   (rst_n),
    .start         (start),
    .m_axil_araddr (araddr),
    .m_axil_arprot (arprot),
    .m_axil_arvalid(arvalid),
    .m_axil_arready(arready),
    .m_axil_rdata  (rdata),
    .m_axil_rresp  (rresp),
    .m_axil_rvalid (rvalid),
    .m_axil_rready (rready),
    .busy          (busy),
    .done          (done),
    .dna_valid     (dna_valid),
    .dna_match     (dna_match),
    .family        (family),
    .dna           (dna),
    .err_resp      (err_resp),
    .err_timeout   (err_timeout)
  );

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responder scenario: 0 good, 1 bit60 flipped, 2 bit0 flipped, 3 zeros for two passes,
  // 4 always zeros, 5 SLVERR on word 1.
  int   mode = 0;
  bit   stall_en = 1'b0;
  int   rd_cnt = 0;
  int   base_cnt = 0;
  logic pend;
  int   rdel;

  function automatic logic [31:0] good_word(input logic [1:0] w);
    case (w)
      2'd0:    return 32'h0405_0607;
      2'd1:    return 32'h0001_0203;
      2'd2:    return 32'h0000_0000;
      default: return 32'h0000_0007;
    endcase
  endfunction

  function automatic logic [31:0] resp_word(input int m, input int pass, input logic [1:0] w);
    case (m)
      1:       return (w == 2'd1) ? 32'h1001_0203 : good_word(w);
      2:       return (w == 2'd0) ? 32'h0405_0606 : good_word(w);
      3:       return (pass < 2) ? 32'h0 : good_word(w);
      4:       return 32'h0;
      default: return good_word(w);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'h0;
      rresp   <= 2'b00;
      pend    <= 1'b0;
      rdel    <= 0;
    end else begin
      arready <= stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (arvalid && arready) begin
        rdata  <= resp_word(mode, (rd_cnt - base_cnt) / 4, araddr[3:2]);
        rresp  <= (mode == 5 && araddr[3:2] == 2'd1) ? 2'b10 : 2'b00;
        rd_cnt <= rd_cnt + 1;
        if (stall_en) begin
          pend <= 1'b1;
          rdel <= $urandom_range(0, 4);
        end else begin
          rvalid <= 1'b1;
        end
      end else if (pend) begin
        if (rdel == 0) begin
          rvalid <= 1'b1;
          pend   <= 1'b0;
        end else begin
          rdel <= rdel - 1;
        end
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // Read-address log and stall-stability monitor.
  int          cyc = 0;
  logic [15:0] hs_addr[$];
  int          hs_cyc[$];
  int          viol = 0;
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr = 16'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (arvalid && arready) begin
        hs_addr.push_back(araddr);
        hs_cyc.push_back(cyc);
      end
      if (prev_wait && (!arvalid || araddr != prev_addr)) viol <= viol + 1;
      prev_wait <= arvalid && !arready;
      prev_addr <= araddr;
    end else begin
      prev_wait <= 1'b0;
    end
  end

  task automatic run_seq(input bit pokes, output int busy_cyc, output int done_cnt);
    bit fin;
    busy_cyc = 0;
    done_cnt = 0;
    fin = 1'b0;
    base_cnt = rd_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && !fin; i++) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (!busy && done_cnt > 0) begin
        fin = 1'b1;
      end else begin
        start = pokes && (i % 3 == 1);
        @(negedge clk);
      end
    end
    start = 1'b0;
    check_vec("seq_end", 128'(fin), 128'd1);
  endtask

  int lb;
  int bc;
  int dc;
  bit seen;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("rst_arvalid", 128'(arvalid), 128'd0);
    check_vec("rst_rready", 128'(rready), 128'd0);
    check_vec("rst_busy", 128'(busy), 128'd0);
    check_vec("rst_done", 128'(done), 128'd0);
    check_vec("rst_valid", 128'(dna_valid), 128'd0);
    check_vec("rst_dna", 128'(dna), 128'd0);
    check_vec("rst_family", 128'(family), 128'd0);
    check_vec("rst_araddr", 128'(araddr), 128'd0);
    check_vec("arprot", 128'(arprot), 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal fetch with zero-wait responder
    mode = 0; lb = hs_addr.size();
    run_seq(1'b0, bc, dc);
    check_vec("t1_busy_cycles", 128'(bc), 128'd10);
    check_vec("t1_done_pulses", 128'(dc), 128'd1);
    check_vec("t1_reads", 128'(hs_addr.size() - lb), 128'd4);
    for (int k = 0; k < 4; k++) check_vec("t1_addr", 128'(hs_addr[lb + k]), 128'(4 * k));
    check_vec("t1_dna", 128'(dna), 128'(EXP_DNA));
    check_vec("t1_family", 128'(family), 128'd7);
    check_vec("t1_valid", 128'(dna_valid), 128'd1);
    check_vec("t1_match", 128'(dna_match), 128'd1);
    check_vec("t1_errs", 128'({err_resp, err_timeout}), 128'd0);

    // Difference in masked-out bit 60 still matches
    mode = 1;
    run_seq(1'b0, bc, dc);
    check_vec("t2_match_bit60", 128'(dna_match), 128'd1);
    check_vec("t2_dna_bit60", 128'(dna), 128'h0000_0000_1001_0203_0405_0607);

    // Difference in bit 0 does not match
    mode = 2;
    run_seq(1'b0, bc, dc);
    check_vec("t2_match_bit0", 128'(dna_match), 128'd0);
    check_vec("t2_valid_bit0", 128'(dna_valid), 128'd1);

    // Two empty passes then data: 12 reads, 8 idle cycles between passes
    mode = 3; lb = hs_addr.size();
    run_seq(1'b0, bc, dc);
    check_vec("t3_reads", 128'(hs_addr.size() - lb), 128'd12);
    check_vec("t3_gap1", 128'(hs_cyc[lb + 4] - hs_cyc[lb + 3]), 128'd11);
    check_vec("t3_gap2", 128'(hs_cyc[lb + 8] - hs_cyc[lb + 7]), 128'd11);
    check_vec("t3_valid", 128'(dna_valid), 128'd1);
    check_vec("t3_timeout", 128'(err_timeout), 128'd0);
    check_vec("t3_match", 128'(dna_match), 128'd1);

    // Never ready: timeout after MAX_RETRIES passes
    mode = 4; lb = hs_addr.size();
    run_seq(1'b0, bc, dc);
    check_vec("t4_reads", 128'(hs_addr.size() - lb), 128'd12);
    check_vec("t4_timeout", 128'(err_timeout), 128'd1);
    check_vec("t4_valid", 128'(dna_valid), 128'd0);
    check_vec("t4_dna", 128'(dna), 128'd0);
    check_vec("t4_done_pulses", 128'(dc), 128'd1);

    // Error response on word 1
    mode = 5; lb = hs_addr.size();
    run_seq(1'b0, bc, dc);
    check_vec("t5_reads", 128'(hs_addr.size() - lb), 128'd2);
    check_vec("t5_err_resp", 128'(err_resp), 128'd1);
    check_vec("t5_valid", 128'(dna_valid), 128'd0);
    check_vec("t5_family", 128'(family), 128'd0);
    check_vec("t5_done_pulses", 128'(dc), 128'd1);

    // Random stalls plus start pokes while busy
    mode = 0; stall_en = 1'b1; lb = hs_addr.size();
    run_seq(1'b1, bc, dc);
    check_vec("t6_done_pulses", 128'(dc), 128'd1);
    check_vec("t6_valid", 128'(dna_valid), 128'd1);
    check_vec("t6_match", 128'(dna_match), 128'd1);
    check_vec("t6_addr3", 128'(hs_addr[lb + 3]), 128'h000C);
    repeat (10) @(negedge clk);
    check_vec("t6_reads", 128'(hs_addr.size() - lb), 128'd4);
    check_vec("t6_idle_after", 128'(busy), 128'd0);
    check_vec("t6_stable", 128'(viol), 128'd0);

    // Reset asserted while in R
    stall_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (rready) seen = 1'b1;
      else @(negedge clk);
    end
    check_vec("t7_reached_r", 128'(seen), 128'd1);
    rst_n = 1'b0;
    #1;
    check_vec("t7_arvalid", 128'(arvalid), 128'd0);
    check_vec("t7_rready", 128'(rready), 128'd0);
    check_vec("t7_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_vec("t7_idle_busy", 128'(busy), 128'd0);
    check_vec("t7_idle_arvalid", 128'(arvalid), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
